// File: rtl/router_pkg.sv
// Shared constants and entry layout for the router output FIFO.
package router_pkg;
   localparam int DATA_W  = 8;
   localparam int DEPTH   = 16;
   localparam int ADDR_W  = 4;
   localparam int LEN_MSB = 7;
   localparam int LEN_LSB = 2;

   typedef struct packed {
      logic              hdr;
      logic [DATA_W-1:0] data;
   } entry_t;
endpackage

// File: rtl/router_fifo.sv
// Per-output-port packet FIFO of the 1x3 router; tracks remaining bytes of the packet being read.
// Optional: ROUTER_FIFO_TRISTATE_EN makes the idle dataout value 'z instead of 8'h00.
module router_fifo #(
   parameter int DATA_W = router_pkg::DATA_W,
   parameter int DEPTH  = router_pkg::DEPTH,
   parameter int ADDR_W = router_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              soft_reset,
   input  logic              write_enb,
   input  logic              read_enb,
   input  logic              lfd_state,
   input  logic [DATA_W-1:0] datain,
   output logic              full,
   output logic              empty,
   output logic [DATA_W-1:0] dataout
);
   import router_pkg::*;

`ifdef ROUTER_FIFO_TRISTATE_EN
   localparam logic [DATA_W-1:0] IDLE = 'z;
`else
   localparam logic [DATA_W-1:0] IDLE = '0;
`endif

   entry_t            mem [DEPTH];
   logic [ADDR_W:0]   wp, rp;
   logic [6:0]        pkt_count;
   logic              last_pend;   // last payload byte just left; release dataout on next idle cycle
   logic              rd_ok, wr_ok;
   entry_t            rd_ent;

   assign full   = (wp[ADDR_W] != rp[ADDR_W]) && (wp[ADDR_W-1:0] == rp[ADDR_W-1:0]);
   assign empty  = (wp == rp);
   assign rd_ok  = read_enb && !empty;
   // A read on the same edge frees the slot, so a full FIFO still accepts the write.
   assign wr_ok  = write_enb && (!full || rd_ok);
   assign rd_ent = mem[rp[ADDR_W-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp        <= '0;
         rp        <= '0;
         pkt_count <= '0;
         last_pend <= 1'b0;
         dataout   <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (soft_reset) begin
         wp        <= '0;
         rp        <= '0;
         pkt_count <= '0;
         last_pend <= 1'b0;
         dataout   <= IDLE;
      end else begin
         if (wr_ok) begin
            mem[wp[ADDR_W-1:0]] <= '{hdr: lfd_state, data: datain};
            wp                  <= wp + (ADDR_W+1)'(1);
         end
         if (rd_ok) begin
            rp      <= rp + (ADDR_W+1)'(1);
            dataout <= rd_ent.data;
            if (rd_ent.hdr) begin
               pkt_count <= 7'(rd_ent.data[LEN_MSB:LEN_LSB]) + 7'd1;
               last_pend <= 1'b0;
            end else if (pkt_count != '0) begin
               pkt_count <= pkt_count - 7'd1;
               last_pend <= (pkt_count == 7'd1);
            end else begin
               last_pend <= 1'b0;
            end
         end else if (last_pend) begin
            dataout   <= IDLE;
            last_pend <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_router_fifo.sv
// Randomized bench for router_fifo against a queue-based packet model.
module tb_router_fifo;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       srst = 1'b0, wr = 1'b0, rd = 1'b0, lfd = 1'b0;
   logic [7:0] din = '0;
   logic       full, empty;
   logic [7:0] dataout;

`ifdef ROUTER_FIFO_TRISTATE_EN
   localparam logic [7:0] IDLE = 'z;
`else
   localparam logic [7:0] IDLE = '0;
`endif

   router_fifo dut (
      .clk(clk), .rst(rst), .soft_reset(srst), .write_enb(wr), .read_enb(rd),
      .lfd_state(lfd), .datain(din), .full(full), .empty(empty), .dataout(dataout)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;

   logic [8:0] q[$];
   int         m_cnt = 0;
   bit         m_pend = 0;
   logic [7:0] m_dout = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      else n_pass++;
   endtask

   task automatic model_reset();
      q.delete(); m_cnt = 0; m_pend = 0; m_dout = '0;
   endtask

   task automatic check_outputs();
      chk("full",    32'(full),          32'(q.size() == 16));
      chk("empty",   32'(empty),         32'(q.size() == 0));
      chk("dataout", 32'(dataout),       32'(m_dout));
      chk("count",   32'(dut.pkt_count), 32'(m_cnt));
   endtask

   // Advance one clock with the currently driven inputs, updating the model from pre-edge state.
   task automatic step();
      bit rd_ok, wr_ok;
      logic [8:0] e;
      if (srst) begin
         q.delete(); m_cnt = 0; m_pend = 0; m_dout = IDLE;
      end else begin
         rd_ok = rd && (q.size() > 0);
         wr_ok = wr && ((q.size() < 16) || rd_ok);
         if (rd_ok) begin
            e = q.pop_front();
            m_dout = e[7:0];
            if (e[8]) begin
               m_cnt = int'(e[7:2]) + 1; m_pend = 0;
            end else if (m_cnt != 0) begin
               m_cnt--; m_pend = (m_cnt == 0);
            end else m_pend = 0;
         end else if (m_pend) begin
            m_dout = IDLE; m_pend = 0;
         end
         if (wr_ok) q.push_back({lfd, din});
      end
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic drive(input logic w, input logic r, input logic l, input logic [7:0] d);
      wr = w; rd = r; lfd = l; din = d; srst = 1'b0;
      step();
   endtask

   initial begin
      logic [7:0] hdr;
      model_reset();
      #1 check_outputs();
      @(negedge clk); rst = 1'b1;
      repeat (2) drive(0, 0, 0, 8'h00);

      // Fill, overflow write dropped, drain in order
      for (int i = 1; i <= 16; i++) drive(1, 0, 0, 8'(i));
      drive(1, 0, 0, 8'hFF);
      for (int i = 0; i < 16; i++) drive(0, 1, 0, 8'h00);
      drive(0, 1, 0, 8'h00);

      // Packet: header length 3, 3 payload + parity, then idle cycle releases dataout
      hdr = 8'h0C;
      drive(1, 0, 1, hdr);
      for (int i = 0; i < 4; i++) drive(1, 0, 0, 8'($urandom));
      for (int i = 0; i < 5; i++) drive(0, 1, 0, 8'h00);
      drive(0, 0, 0, 8'h00);
      chk("pkt_idle", 32'(dataout), 32'(IDLE));

      // Concurrent read/write when full, then when empty
      for (int i = 0; i < 16; i++) drive(1, 0, 0, 8'($urandom));
      for (int i = 0; i < 3; i++) drive(1, 1, 0, 8'($urandom));
      for (int i = 0; i < 16; i++) drive(0, 1, 0, 8'h00);
      drive(1, 1, 0, 8'h5A);
      drive(0, 1, 0, 8'h00);

      // Soft reset with bytes queued; same-cycle write discarded
      for (int i = 0; i < 5; i++) drive(1, 0, 0, 8'($urandom));
      drive(0, 1, 0, 8'h00);
      wr = 1; rd = 0; din = 8'hAA; srst = 1; step();
      chk("srst_idle", 32'(dataout), 32'(IDLE));
      drive(0, 1, 0, 8'h00);

      // Randomized traffic with occasional flush
      for (int i = 0; i < 600; i++) begin
         wr   = 1'($urandom_range(0, 2) != 0);
         rd   = 1'($urandom_range(0, 2) != 0);
         lfd  = 1'($urandom_range(0, 5) == 0);
         din  = 8'($urandom);
         srst = 1'($urandom_range(0, 60) == 0);
         step();
      end

      // Async reset between edges takes effect immediately
      for (int i = 0; i < 5; i++) drive(1, 0, 0, 8'($urandom));
      drive(1, 1, 1, 8'h10);
      wr = 0; rd = 0; srst = 0;
      #2 rst = 1'b0;
      #1 model_reset();
      check_outputs();
      @(negedge clk);
      check_outputs();
      rst = 1'b1;
      drive(0, 1, 0, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
